// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the control unit.
// It holds the 8-bit PC and fetches 16-bit instructions over a req/ack
// handshake. Each instruction is held in the IR for one or more execute
// cycles. Jump and branch redirects are applied when the stage leaves EXEC.
// Optional feature macro: FETCH_WRAP_HALT_EN. When it is defined, a
// sequential step past PC 8'hFF parks the block in HALT instead of
// wrapping to 8'h00.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        exec_stall,
    input  logic        pc_jump,
    input  logic        pc_branch,
    input  logic [7:0]  RAM_adr,
    output logic        imem_req,
    output logic [7:0]  imem_adr,
    input  logic [15:0] imem_data,
    input  logic        imem_ack,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        req_q;
    logic        valid_q;

    // Next-state, next-PC and IR-load decision
    // NOTE: every signal written here gets a default value first. Any path
    // that skipped an assignment would otherwise make synthesis infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                // An ack is only meaningful while the request is outstanding
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // A stall freezes the stage; redirects are only looked at on exit
                if (!exec_stall) begin
                    state_d = run ? FETCH : IDLE;
                    if (pc_jump || pc_branch) begin
                        // Jump and branch share one target, so no priority is needed
                        pc_d = RAM_adr;
                    end
`ifdef FETCH_WRAP_HALT_EN
                    else if (pc_q == 8'hFF) begin
                        // Running off the end of memory parks the block; PC stays at FF
                        state_d = HALT;
                    end
`endif
                    else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            HALT: begin
                // Only reset leaves HALT
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC, IR and registered output flags; async reset clears them at once
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together on the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            // The flags are decoded from the next state, so each one is
            // valid in the same cycle the FSM enters its state.
            req_q   <= (state_d == FETCH);
            valid_q <= (state_d == EXEC);
        end
    end

`ifdef FETCH_WRAP_HALT_EN
    logic halted_q;

    // Registered HALT indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == HALT);
        end
    end

    assign halted = halted_q;
`else
    // Without the wrap-halt feature, HALT is unreachable
    assign halted = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_adr    = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. It has three parts:
// - a per-cycle vector table for the basic fetch/exec/redirect flow,
// - hand-written sequences for reset, run-drop and PC wrap corner cases,
// - randomized stimulus checked against a behavioural model.
module tb_fetch_unit;

`ifdef FETCH_WRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        exec_stall = 1'b0;
    logic        pc_jump = 1'b0;
    logic        pc_branch = 1'b0;
    logic [7:0]  RAM_adr = 8'h00;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_adr;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .exec_stall  (exec_stall),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .RAM_adr     (RAM_adr),
        .imem_req    (imem_req),
        .imem_adr    (imem_adr),
        .imem_data   (imem_data),
        .imem_ack    (imem_ack),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        stall;
        logic        jmp;
        logic        br;
        logic [7:0]  adr;
        logic        ack;
        logic [15:0] data;
        logic        e_req;
        logic [7:0]  e_pc;
        logic [15:0] e_ir;
        logic        e_valid;
    } vec_t;

    vec_t vecs[18];

    // Behavioural model for the random phase
    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT} mode_e;
    mode_e       m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [7:0] p,
                              input logic [15:0] ir, input logic v, input logic h);
        check({tag, ".req"},    {15'b0, imem_req},    {15'b0, req});
        check({tag, ".adr"},    {8'b0, imem_adr},     {8'b0, p});
        check({tag, ".pc"},     {8'b0, pc},           {8'b0, p});
        check({tag, ".ir"},     instruction,          ir);
        check({tag, ".valid"},  {15'b0, instr_valid}, {15'b0, v});
        check({tag, ".halted"}, {15'b0, halted},      {15'b0, h});
    endtask

    // Drive inputs on the falling edge, then let one rising edge pass and settle
    task automatic cycle(input logic r, input logic s, input logic j, input logic b,
                         input logic [7:0] a, input logic k, input logic [15:0] d);
        @(negedge clk);
        run = r; exec_stall = s; pc_jump = j; pc_branch = b;
        RAM_adr = a; imem_ack = k; imem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0; exec_stall = 1'b0; pc_jump = 1'b0; pc_branch = 1'b0;
        RAM_adr = 8'h00; imem_ack = 1'b0; imem_data = 16'h0000;
        #1;
        check_outs("reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, fetch one instruction at 0, then jump so the next fetch is at target
    task automatic go_to(input logic [7:0] target);
        do_reset();
        cycle(1, 0, 0, 0, 8'h00, 0, 16'h0000);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'h0C0C);
        cycle(1, 0, 1, 0, target, 0, 16'h0000);
        check_outs("goto", 1'b1, target, 16'h0C0C, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic j, input logic b,
                                input logic [7:0] a, input logic k, input logic [15:0] d,
                                input logic er, input logic [7:0] ep,
                                input logic [15:0] ei, input logic ev);
        vec_t t;
        t.run = r; t.stall = s; t.jmp = j; t.br = b; t.adr = a; t.ack = k; t.data = d;
        t.e_req = er; t.e_pc = ep; t.e_ir = ei; t.e_valid = ev;
        return t;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic j, input logic b,
                              input logic [7:0] a, input logic k, input logic [15:0] d);
        case (m_mode)
            M_IDLE:  if (r) m_mode = M_FETCH;
            M_FETCH: if (k) begin m_ir = d; m_mode = M_EXEC; end
            M_EXEC: begin
                if (!s) begin
                    if (j || b) begin
                        m_pc = a;
                        m_mode = r ? M_FETCH : M_IDLE;
                    end else if (HALT_EN && m_pc == 8'hFF) begin
                        m_mode = M_HALT;
                    end else begin
                        m_pc = 8'(m_pc + 8'd1);
                        m_mode = r ? M_FETCH : M_IDLE;
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        //        run stl jmp br  adr    ack data      | req pc     ir        valid
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 16'h0000,  1, 8'h00, 16'h0000, 0);
        vecs[1]  = mk(1, 0, 0, 0, 8'h00, 1, 16'h0123,  0, 8'h00, 16'h0123, 1);
        vecs[2]  = mk(1, 0, 0, 0, 8'h00, 0, 16'h0000,  1, 8'h01, 16'h0123, 0);
        vecs[3]  = mk(1, 0, 0, 0, 8'h00, 0, 16'hFFFF,  1, 8'h01, 16'h0123, 0);
        vecs[4]  = mk(1, 0, 0, 0, 8'h00, 0, 16'hFFFF,  1, 8'h01, 16'h0123, 0);
        vecs[5]  = mk(1, 0, 0, 0, 8'h00, 1, 16'hABCD,  0, 8'h01, 16'hABCD, 1);
        vecs[6]  = mk(1, 1, 1, 0, 8'h40, 1, 16'h1111,  0, 8'h01, 16'hABCD, 1);
        vecs[7]  = mk(1, 0, 1, 0, 8'h40, 0, 16'h0000,  1, 8'h40, 16'hABCD, 0);
        vecs[8]  = mk(1, 0, 0, 0, 8'h00, 1, 16'h5555,  0, 8'h40, 16'h5555, 1);
        vecs[9]  = mk(1, 1, 0, 1, 8'h10, 0, 16'h0000,  0, 8'h40, 16'h5555, 1);
        vecs[10] = mk(1, 1, 0, 1, 8'h10, 0, 16'h0000,  0, 8'h40, 16'h5555, 1);
        vecs[11] = mk(1, 0, 0, 1, 8'h10, 0, 16'h0000,  1, 8'h10, 16'h5555, 0);
        vecs[12] = mk(1, 0, 0, 0, 8'h00, 1, 16'h0707,  0, 8'h10, 16'h0707, 1);
        vecs[13] = mk(0, 0, 0, 0, 8'h00, 0, 16'h0000,  0, 8'h11, 16'h0707, 0);
        vecs[14] = mk(0, 0, 0, 0, 8'h00, 1, 16'h9999,  0, 8'h11, 16'h0707, 0);
        vecs[15] = mk(1, 0, 0, 0, 8'h00, 0, 16'h0000,  1, 8'h11, 16'h0707, 0);
        vecs[16] = mk(1, 0, 1, 1, 8'h20, 1, 16'h2222,  0, 8'h11, 16'h2222, 1);
        vecs[17] = mk(1, 0, 1, 1, 8'h20, 0, 16'h0000,  1, 8'h20, 16'h2222, 0);

        // Reset state, then IDLE must hold while run is low
        do_reset();
        cycle(0, 0, 0, 0, 8'h00, 1, 16'h7777);
        check_outs("idle_hold", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].run, vecs[i].stall, vecs[i].jmp, vecs[i].br,
                  vecs[i].adr, vecs[i].ack, vecs[i].data);
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc,
                       vecs[i].e_ir, vecs[i].e_valid, 1'b0);
        end

        // run dropped in EXEC at pc 0x07: go IDLE with pc 0x08, then resume there
        go_to(8'h07);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'h4321);
        check_outs("rundrop_exec", 1'b0, 8'h07, 16'h4321, 1'b1, 1'b0);
        cycle(0, 0, 0, 0, 8'h00, 0, 16'h0000);
        check_outs("rundrop_idle", 1'b0, 8'h08, 16'h4321, 1'b0, 1'b0);
        cycle(0, 0, 0, 0, 8'h00, 0, 16'h0000);
        check_outs("rundrop_idle2", 1'b0, 8'h08, 16'h4321, 1'b0, 1'b0);
        cycle(1, 0, 0, 0, 8'h00, 0, 16'h0000);
        check_outs("rundrop_resume", 1'b1, 8'h08, 16'h4321, 1'b0, 1'b0);

        // Asynchronous reset mid-FETCH at pc 0x05; a late ack must be ignored
        do_reset();
        cycle(1, 0, 0, 0, 8'h00, 0, 16'h0000);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'h0000);
        cycle(1, 0, 1, 0, 8'h05, 0, 16'h0000);
        check_outs("midfetch_pre", 1'b1, 8'h05, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("midfetch_async", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_data = 16'hDEAD;
        @(posedge clk);
        #1;
        check_outs("midfetch_lateack", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

        // Sequential exit from pc 0xFF
        go_to(8'hFF);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'hF00D);
        check_outs("ff_exec", 1'b0, 8'hFF, 16'hF00D, 1'b1, 1'b0);
        cycle(1, 0, 0, 0, 8'h00, 0, 16'h0000);
`ifdef FETCH_WRAP_HALT_EN
        check_outs("ff_halt", 1'b0, 8'hFF, 16'hF00D, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 1, 8'h33, 1, 16'hBEEF);
            check_outs($sformatf("ff_halt_hold%0d", i), 1'b0, 8'hFF, 16'hF00D, 1'b0, 1'b1);
        end
`else
        check_outs("ff_wrap", 1'b1, 8'h00, 16'hF00D, 1'b0, 1'b0);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'h0A0A);
        check_outs("ff_wrap_exec", 1'b0, 8'h00, 16'h0A0A, 1'b1, 1'b0);
`endif

        // A redirect taken from 0xFF never halts
        go_to(8'hFF);
        cycle(1, 0, 0, 0, 8'h00, 1, 16'h1234);
        cycle(1, 0, 1, 0, 8'h30, 0, 16'h0000);
        check_outs("ff_redirect", 1'b1, 8'h30, 16'h1234, 1'b0, 1'b0);

        // Randomized stimulus against the behavioural model
        do_reset();
        m_mode = M_IDLE;
        m_pc   = 8'h00;
        m_ir   = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            logic        r, s, j, b, k;
            logic [7:0]  a;
            logic [15:0] d;
            r = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 1) == 0);
            a = 8'($urandom);
            d = 16'($urandom);
            cycle(r, s, j, b, a, k, d);
            model_step(r, s, j, b, a, k, d);
            check_outs("rand", m_mode == M_FETCH, m_pc, m_ir, m_mode == M_EXEC, m_mode == M_HALT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the control unit. Holds the 8-bit program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake. Presents each instruction to the control unit for one or more execute cycles. Applies jump/branch redirects (`pc_jump`, `pc_branch`, `RAM_adr`) returned by the control unit when it selects the next PC.

## Interface
- `RESET_PC`, default `8'h00`: PC value loaded on reset.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  start/continue fetching; sampled in IDLE and at EXEC exit.
- `exec_stall`  in  1  holds the current instruction in EXEC.
- `pc_jump`  in  1  jump redirect from control unit, sampled at EXEC exit.
- `pc_branch`  in  1  taken-branch redirect from control unit, sampled at EXEC exit.
- `RAM_adr`  in  8  redirect target from control unit.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_adr`  out  8  fetch address; equals `pc`.
- `imem_data`  in  16  instruction word; valid when `imem_ack`=1.
- `imem_ack`  in  1  memory completes the request this cycle.
- `instruction`  out  16  instruction register (IR) to control unit.
- `instr_valid`  out  1  IR holds an instruction under execution.
- `pc`  out  8  current program counter.
- `halted`  out  1  block is in HALT.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT. All outputs are registered.
- Reset values: state=IDLE, `pc`=RESET_PC, IR=16'h0000, `imem_req`=0, `instr_valid`=0, `halted`=0.
- IDLE: `run`=1 moves to FETCH. `run`=0 stays in IDLE.
- FETCH: `imem_req`=1 and `imem_adr`=`pc`. Both are held stable until ack. On `imem_ack`=1: IR<=`imem_data`, then go to EXEC.
- EXEC: `instr_valid`=1 and IR is stable.
    - `exec_stall`=1 keeps the block in EXEC and the redirect inputs are ignored.
    - With `exec_stall`=0 the next PC is selected:
        - `pc_jump` or `pc_branch`: next PC = `RAM_adr`. When both are set the target is the same `RAM_adr`; no conflict.
        - Otherwise: next PC = `pc`+1, modulo 256.
    - Next state on exit: `run`=1 goes to FETCH; `run`=0 goes to IDLE. PC is updated in either case.
- HALT: entered only per Configuration. It is left only by `rst`. `halted`=1, `imem_req`=0, `instr_valid`=0.
- `imem_ack` outside FETCH is ignored; IR and state are unchanged.
- Redirect inputs outside EXEC are ignored.
- `instruction` retains the last IR value outside EXEC. Consumers qualify it with `instr_valid`.

## Timing
- `imem_req` rises in the first clock cycle after the FSM enters FETCH. It falls in the cycle after the cycle in which `imem_ack` was sampled high.
- An ack in the first FETCH cycle is legal. The minimum FETCH duration is 1 cycle.
- Minimum instruction period is 2 cycles (1 FETCH + 1 EXEC).
- The new PC appears on `pc`/`imem_adr` in the same cycle as the first FETCH cycle after EXEC exit.
- A redirect costs no extra cycle compared with sequential fetch.
- `rst` asserted at any point, including mid-FETCH with `imem_req` high, forces all outputs to their reset values immediately, without waiting for a clock edge.
- Memory must tolerate a dropped request. A late `imem_ack` after reset is ignored.
- Reset release: the block remains in IDLE until `run`=1 is sampled on a clock edge.

## Configuration
- Macro: `FETCH_WRAP_HALT_EN`.
- Defined: a sequential increment from `pc`=8'hFF (no redirect) enters HALT. `pc` remains 8'hFF and `halted` goes to 1 on the next cycle.
- A redirect taken from 8'hFF does not halt.
- Undefined: `pc` wraps to 8'h00 and fetching continues. HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset, `run`=1, memory acks on the 1st request cycle with data 16'h0123 at 0x00:
    - -> `imem_adr`=0x00, IR=16'h0123.
    - -> `instr_valid` high for exactly 1 cycle.
    - -> next fetch at 0x01, with a 2-cycle instruction period.
- Ack delayed 3 cycles:
    - -> `imem_req` and `imem_adr` are stable for 3 cycles.
    - -> IR loads only on the ack cycle.
    - -> stray acks during EXEC are ignored.
- Redirect checks:
    - EXEC with `pc_jump`=1, `RAM_adr`=0x40 -> next fetch at 0x40.
    - `pc_branch`=1, `RAM_adr`=0x10 with `exec_stall`=1 for 2 cycles -> redirect ignored while stalled; applied at exit -> fetch at 0x10.
- `rst` pulsed mid-FETCH at `pc`=0x05 -> `imem_req`=0 and `pc`=RESET_PC immediately; an ack arriving 1 cycle later leaves IR=0.
- `pc`=0xFF sequential exit:
    - -> with `FETCH_WRAP_HALT_EN`, `halted`=1 and there are no further requests.
    - -> without the macro, the next fetch is at 0x00.
- `run` dropped during EXEC at `pc`=0x07 -> IDLE with `pc`=0x08; `run` reasserted -> fetch at 0x08.
